fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port pc_out, output, 32 bits, current PC register; feeds the next-PC block's p_in.
REQ-005 SHALL have port next_pc, input, 32 bits, next-PC block's p_out (pc+4 or branch target).
REQ-006 SHALL have port flush, input, 1 bit, redirect request from a later stage.
REQ-007 SHALL have port redirect_pc, input, 32 bits, PC to load on flush.
REQ-008 SHALL have port stall, input, 1 bit, downstream cannot accept a new IF/ID entry.
REQ-009 SHALL have port imem_req, output, 1 bit, instruction-memory request valid.
REQ-010 SHALL have port imem_addr, output, 32 bits, request address.
REQ-011 SHALL have port imem_ack, input, 1 bit, response valid this cycle.
REQ-012 SHALL have port imem_rdata, input, 32 bits, instruction word, valid with imem_ack.
REQ-013 SHALL have port if_id_valid, output, 1 bit, IF/ID entry holds a real instruction.
REQ-014 SHALL have port if_id_instr, output, 32 bits, registered instruction; bits [15:0] feed the next-PC block's instruct.
REQ-015 SHALL have port if_id_pc4, output, 32 bits, registered PC+4 of that instruction.

Function
REQ-016 SHALL implement states S_IDLE, S_REQ, S_HOLD, S_DROP.
REQ-017 SHALL drive imem_req=1 only in S_REQ and S_DROP, with imem_addr=pc_out held stable until imem_ack.
REQ-018 S_IDLE SHALL go to S_REQ unconditionally on the next cycle.
REQ-019 S_REQ with imem_ack and no stall: load IF/ID (instr=imem_rdata, pc4=pc_out+4 modulo 2^32, valid=1), load PC from next_pc, stay in S_REQ.
REQ-020 S_REQ with imem_ack and stall: capture imem_rdata into a hold buffer, keep PC and IF/ID unchanged, go to S_HOLD.
REQ-021 S_REQ without imem_ack: if stall is 0, set if_id_valid=0 (bubble); if stall is 1, hold IF/ID; PC is unchanged either way.
REQ-022 S_HOLD SHALL keep imem_req=0; when stall is 0, load IF/ID from the hold buffer with pc4=pc_out+4, load PC from next_pc, and go to S_REQ.
REQ-023 Flush SHALL take priority over stall and ack: if_id_valid=0 next cycle and PC loaded from redirect_pc.
REQ-024 Flush in S_REQ with no same-cycle ack SHALL go to S_DROP and keep the old imem_addr; the returning response SHALL be discarded.
REQ-025 S_DROP SHALL stay until imem_ack, then drive imem_addr from the new PC and go to S_REQ; IF/ID stays invalid.
REQ-026 Flush in S_DROP SHALL reload PC from redirect_pc and stay in S_DROP.
REQ-027 Flush in S_REQ with same-cycle ack, or in S_HOLD/S_IDLE, SHALL go to S_REQ and discard the fetched word.
REQ-028 if_id_instr and if_id_pc4 SHALL hold their values whenever IF/ID is not loaded; only if_id_valid changes on a bubble.
REQ-029 next_pc SHALL be sampled only in the cycle the PC advances; no other PC arithmetic beyond pc+4 for if_id_pc4.

Reset
REQ-030 rst_n=0 SHALL immediately force state=S_IDLE, pc_out=RESET_PC, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc4=0, and hold buffer=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; any ack arriving in S_IDLE SHALL be ignored.
REQ-032 The first request after rst_n rises SHALL be issued in the second cycle, at imem_addr=RESET_PC.

Verification
REQ-033 Reset release, with imem acking every cycle and next_pc=pc_out+4 -> imem_addr 0,4,8; if_id_pc4 4,8,12 on consecutive cycles; if_id_valid=1 from the first ack.
REQ-034 imem_ack delayed 3 cycles at PC 0x10 -> imem_addr stays 0x10, if_id_valid=0 for those cycles, then instr loaded with if_id_pc4=0x14.
REQ-035 stall=1 in the ack cycle at PC 0x20 for 2 cycles -> IF/ID unchanged, imem_req=0 while held; on stall=0 the buffered word loads with if_id_pc4=0x24.
REQ-036 flush=1 with redirect_pc=0x100 while a request to 0x40 is pending -> imem_addr held at 0x40 until ack, that word discarded, next request at 0x100, if_id_valid=0 meanwhile.
REQ-037 flush and stall both 1 in the same cycle -> flush wins: if_id_valid=0 and PC=redirect_pc.
REQ-038 rst_n pulsed low mid-request -> outputs reach reset values without a clock edge; a late ack is ignored; the next request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC register, instruction-memory request FSM and IF/ID register
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic        valid_nxt;
  logic [31:0] instr_nxt, pc4_nxt;

  assign pc_out    = pc;
  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  // An abandoned request must keep its address until its response returns.
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      hold_buf    <= 32'h0;
      drop_addr   <= 32'h0;
      if_id_valid <= 1'b0;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      hold_buf    <= hold_buf_nxt;
      drop_addr   <= drop_addr_nxt;
      if_id_valid <= valid_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc4   <= pc4_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    hold_buf_nxt  = hold_buf;
    drop_addr_nxt = drop_addr;
    valid_nxt     = if_id_valid;
    instr_nxt     = if_id_instr;
    pc4_nxt       = if_id_pc4;

    if (flush) begin
      valid_nxt = 1'b0;
      pc_nxt    = redirect_pc;
      if (state == S_REQ && !imem_ack) begin
        state_nxt     = S_DROP;
        drop_addr_nxt = pc;
      end else if (state == S_DROP && !imem_ack) begin
        state_nxt = S_DROP;
      end else begin
        // A response landing with the flush is the stale one; nothing left to drop.
        state_nxt = S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (imem_ack && !stall) begin
            valid_nxt = 1'b1;
            instr_nxt = imem_rdata;
            pc4_nxt   = pc + 32'd4;
            pc_nxt    = next_pc;
          end else if (imem_ack) begin
            hold_buf_nxt = imem_rdata;
            state_nxt    = S_HOLD;
          end else if (!stall) begin
            valid_nxt = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            valid_nxt = 1'b1;
            instr_nxt = hold_buf;
            pc4_nxt   = pc + 32'd4;
            pc_nxt    = next_pc;
            state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          valid_nxt = 1'b0;
          if (imem_ack) state_nxt = S_REQ;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
